// File: rtl/microroc_readout_deser_pkg.sv
// -----------------------------------------------------------------------------
// microroc_readout_deser_pkg
//   Shared definitions for the MICROROC serial readout deserializer:
//   FSM state encoding, MICROROC frame field widths, default word/frame
//   sizes, the default trailer word, and a saturating 16-bit increment.
// -----------------------------------------------------------------------------
package microroc_readout_deser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_TRAILER = 2'd3
    } state_t;

    // MICROROC frame layout: BCID, hit bits, chip ID
    localparam int unsigned BCID_W         = 24;
    localparam int unsigned HIT_W          = 128;
    localparam int unsigned CHIPID_W       = 8;
    localparam int unsigned FRAME_BITS_DEF = BCID_W + HIT_W + CHIPID_W;

    localparam int unsigned WORD_W_DEF  = 16;
    localparam logic [15:0] TRAILER_DEF = 16'hFFFF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == '1) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/microroc_readout_deser_sync2_edge.sv
// -----------------------------------------------------------------------------
// sync2_edge
//   Two-flop synchronizer for an asynchronous level, plus rise/fall pulses
//   derived from a registered copy of the synchronized level.
//   Ports:
//     Clk      in   system clock
//     reset_n  in   asynchronous active-low reset (all flops -> RESET_VAL)
//     i_async  in   asynchronous input level
//     o_sync   out  synchronized level
//     o_rise   out  one-cycle pulse on synchronized 0->1
//     o_fall   out  one-cycle pulse on synchronized 1->0
// -----------------------------------------------------------------------------
module sync2_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic Clk,
    input  logic reset_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
            r_prev <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/microroc_readout_deser.sv
// -----------------------------------------------------------------------------
// microroc_readout_deser
//   Deserializes the MICROROC readout stream (Dout framed by TransmitOn_n)
//   into MSB-first words for the event FIFO, appends a trailer word at the
//   end of each transmission, counts complete frames and flags errors.
//   Ports:
//     Clk            in   40 MHz system clock
//     reset_n        in   asynchronous active-low reset
//     Start_Readout  in   rising edge clears frame_cnt / partial_err / overflow
//     Dout           in   asynchronous serial data, one bit per Clk
//     TransmitOn_n   in   asynchronous transmission window, active low
//     fifo_full      in   event FIFO full; suppresses the write strobe
//     fifo_din       out  word to FIFO
//     fifo_wr_en     out  one-cycle write strobe
//     frame_cnt      out  complete frames since last clear, saturating
//     partial_err    out  sticky: transmission ended mid-frame / bits dropped
//     overflow       out  sticky: a word was dropped because of fifo_full
//     busy           out  FSM not idle
// -----------------------------------------------------------------------------
module microroc_readout_deser
    import microroc_readout_deser_pkg::*;
#(
    parameter int unsigned       WORD_W     = WORD_W_DEF,
    parameter int unsigned       FRAME_BITS = FRAME_BITS_DEF,
    parameter logic [WORD_W-1:0] TRAILER    = TRAILER_DEF,
    parameter bit                TRAILER_EN = 1'b1
) (
    input  logic              Clk,
    input  logic              reset_n,
    input  logic              Start_Readout,
    input  logic              Dout,
    input  logic              TransmitOn_n,
    input  logic              fifo_full,
    output logic [WORD_W-1:0] fifo_din,
    output logic              fifo_wr_en,
    output logic [15:0]       frame_cnt,
    output logic              partial_err,
    output logic              overflow,
    output logic              busy
);

    localparam int unsigned BC_W = $clog2(WORD_W);
    localparam int unsigned FB_W = $clog2(FRAME_BITS);
    localparam logic [BC_W-1:0] BC_LAST  = BC_W'(WORD_W - 1);
    localparam logic [FB_W-1:0] FB_LAST  = FB_W'(FRAME_BITS - 1);
    localparam logic [BC_W:0]   WORD_W_L = (BC_W + 1)'(WORD_W);

    // ---------------------------------------------------------------- sync
    logic w_ton_s, w_ton_rise, w_ton_fall;
    logic w_sr_s, w_sr_rise, w_sr_fall;
    logic w_unused_edges;
    logic r_dout_meta, r_dout_s;

    sync2_edge #(.RESET_VAL(1'b1)) u_ton_sync (
        .Clk     (Clk),
        .reset_n (reset_n),
        .i_async (TransmitOn_n),
        .o_sync  (w_ton_s),
        .o_rise  (w_ton_rise),
        .o_fall  (w_ton_fall)
    );

    sync2_edge #(.RESET_VAL(1'b0)) u_sr_sync (
        .Clk     (Clk),
        .reset_n (reset_n),
        .i_async (Start_Readout),
        .o_sync  (w_sr_s),
        .o_rise  (w_sr_rise),
        .o_fall  (w_sr_fall)
    );

    assign w_unused_edges = ^{w_ton_rise, w_ton_fall, w_sr_s, w_sr_fall};

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dout_meta <= 1'b0;
            r_dout_s    <= 1'b0;
        end else begin
            r_dout_meta <= Dout;
            r_dout_s    <= r_dout_meta;
        end
    end

    // ----------------------------------------------------------------- FSM
    state_t r_state, w_state_nxt;
    logic   w_shift;        // accept dout_s this cycle
    logic   w_flush;        // emit partial word
    logic   w_trailer;      // emit trailer word
    logic   w_clr_frame;    // transmission ended: restart frame position
    logic   w_set_partial;

    logic [WORD_W-1:0] r_sreg;
    logic [BC_W-1:0]   r_bit_cnt;
    logic [FB_W-1:0]   r_frame_bit;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shift       = 1'b0;
        w_flush       = 1'b0;
        w_trailer     = 1'b0;
        w_clr_frame   = 1'b0;
        w_set_partial = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_ton_s) begin
                    w_shift     = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!w_ton_s) begin
                    w_shift = 1'b1;
                end else begin
                    w_clr_frame   = 1'b1;
                    w_set_partial = (r_frame_bit != '0);
                    if (r_bit_cnt != '0)
                        w_state_nxt = ST_FLUSH;
                    else
                        w_state_nxt = TRAILER_EN ? ST_TRAILER : ST_IDLE;
                end
            end
            ST_FLUSH: begin
                // bits arriving here cannot be captured; they are lost
                w_flush       = 1'b1;
                w_set_partial = !w_ton_s;
                w_state_nxt   = TRAILER_EN ? ST_TRAILER : ST_IDLE;
            end
            ST_TRAILER: begin
                w_trailer     = 1'b1;
                w_set_partial = !w_ton_s;
                w_state_nxt   = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------ datapath
    logic              w_word_done;
    logic              w_frame_done;
    logic [WORD_W-1:0] w_sreg_nxt;
    logic [BC_W:0]     w_pad;
    logic [WORD_W-1:0] w_flush_word;

    assign w_word_done  = w_shift && (r_bit_cnt == BC_LAST);
    assign w_frame_done = w_shift && (r_frame_bit == FB_LAST);
    assign w_sreg_nxt   = {r_sreg[WORD_W-2:0], r_dout_s};
    // stale bits from the previous word sit above the valid ones and are
    // shifted out, leaving the partial word left-aligned and zero-padded
    assign w_pad        = WORD_W_L - {1'b0, r_bit_cnt};
    assign w_flush_word = r_sreg << w_pad;

    logic              r_wr_req;
    logic [WORD_W-1:0] r_din;
    logic [15:0]       r_frame_cnt;
    logic              r_partial;
    logic              r_overflow;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sreg      <= '0;
            r_bit_cnt   <= '0;
            r_frame_bit <= '0;
            r_wr_req    <= 1'b0;
            r_din       <= '0;
            r_frame_cnt <= '0;
            r_partial   <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_wr_req <= 1'b0;

            if (w_shift) begin
                r_sreg      <= w_sreg_nxt;
                r_bit_cnt   <= w_word_done  ? '0 : r_bit_cnt + 1'b1;
                r_frame_bit <= w_frame_done ? '0 : r_frame_bit + 1'b1;
            end
            if (w_clr_frame)
                r_frame_bit <= '0;

            if (w_word_done) begin
                r_din    <= w_sreg_nxt;
                r_wr_req <= 1'b1;
            end else if (w_flush) begin
                r_din     <= w_flush_word;
                r_wr_req  <= 1'b1;
                r_bit_cnt <= '0;
            end else if (w_trailer) begin
                r_din    <= TRAILER;
                r_wr_req <= 1'b1;
            end

            // clear has priority over any same-cycle update
            if (w_sr_rise) begin
                r_frame_cnt <= '0;
                r_partial   <= 1'b0;
                r_overflow  <= 1'b0;
            end else begin
                if (w_frame_done)
                    r_frame_cnt <= sat_inc16(r_frame_cnt);
                if (w_set_partial)
                    r_partial <= 1'b1;
                if (r_wr_req && fifo_full)
                    r_overflow <= 1'b1;
            end
        end
    end

    // full is judged in the strobe cycle itself so the FIFO never sees a
    // write while it reports full
    assign fifo_wr_en  = r_wr_req & ~fifo_full;
    assign fifo_din    = r_din;
    assign frame_cnt   = r_frame_cnt;
    assign partial_err = r_partial;
    assign overflow    = r_overflow;
    assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_microroc_readout_deser.sv
`timescale 1ns/1ps
module tb_microroc_readout_deser;

    logic        Clk = 1'b0;
    logic        reset_n, Start_Readout, Dout, TransmitOn_n, fifo_full;
    logic [15:0] fifo_din;
    logic        fifo_wr_en;
    logic [15:0] frame_cnt;
    logic        partial_err, overflow, busy;

    microroc_readout_deser #(
        .WORD_W     (16),
        .FRAME_BITS (160),
        .TRAILER    (16'hFFFF),
        .TRAILER_EN (1'b1)
    ) dut (
        .Clk           (Clk),
        .reset_n       (reset_n),
        .Start_Readout (Start_Readout),
        .Dout          (Dout),
        .TransmitOn_n  (TransmitOn_n),
        .fifo_full     (fifo_full),
        .fifo_din      (fifo_din),
        .fifo_wr_en    (fifo_wr_en),
        .frame_cnt     (frame_cnt),
        .partial_err   (partial_err),
        .overflow      (overflow),
        .busy          (busy)
    );

    always #12.5 Clk = ~Clk;

    int unsigned cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_q[$];
    bit          tx_bits[$];
    int          m_frames;
    bit          m_partial;
    bit          m_overflow;
    int unsigned n_writes = 0;
    int unsigned first_wr_cyc = 0;
    int unsigned c0;
    logic [15:0] cmp_w;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: expected word stream for one transmission of n bits
    function automatic logic [15:0] word_at(input int start, input int avail);
        logic [15:0] w = '0;
        for (int j = 0; j < 16; j++)
            if (j < avail) w[15-j] = tx_bits[start+j];
        return w;
    endfunction

    task automatic model_window(input int start, input int n);
        for (int i = 0; i < n; i += 16)
            exp_q.push_back(word_at(start + i, n - i));
        exp_q.push_back(16'hFFFF);
        m_frames = m_frames + n / 160;
        if (m_frames > 65535) m_frames = 65535;
        if (n % 160 != 0) m_partial = 1'b1;
    endtask

    task automatic gen_random(input int n);
        tx_bits.delete();
        for (int i = 0; i < n; i++) tx_bits.push_back($urandom_range(0, 1) != 0);
    endtask

    task automatic drive_bits(input int start, input int n, output int unsigned first_cyc);
        first_cyc = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge Clk); #1;
            if (k == 0) first_cyc = cyc;
            TransmitOn_n = 1'b0;
            Dout         = tx_bits[start+k];
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge Clk); #1;
            TransmitOn_n = 1'b1;
            Dout         = 1'b0;
        end
    endtask

    task automatic check_state(input string tag);
        int i = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0) && i < 300) begin
            @(posedge Clk); #1;
            i++;
        end
        repeat (4) begin @(posedge Clk); #1; end
        chk({tag, "_drained"},     exp_q.size(), 0);
        chk({tag, "_busy"},        busy, 0);
        chk({tag, "_frame_cnt"},   frame_cnt, m_frames);
        chk({tag, "_partial_err"}, partial_err, m_partial);
        chk({tag, "_overflow"},    overflow, m_overflow);
    endtask

    // Compare process: every write strobe must match the next expected word
    always @(negedge Clk) begin
        if (reset_n === 1'b1 && fifo_wr_en === 1'b1) begin
            if (n_writes == 0) first_wr_cyc = cyc;
            n_writes++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got %h with no word expected (cycle %0d)", fifo_din, cyc);
            end else begin
                cmp_w = exp_q.pop_front();
                chk("fifo_word", fifo_din, cmp_w);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] pat;
        int          n, gap;

        reset_n = 1'b0; Start_Readout = 1'b0; Dout = 1'b0; TransmitOn_n = 1'b1; fifo_full = 1'b0;
        m_frames = 0; m_partial = 1'b0; m_overflow = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_fifo_din", fifo_din, 0);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_partial", partial_err, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_busy", busy, 0);
        reset_n = 1'b1;
        idle_cycles(4);

        // T1: one frame of A5A5 pattern
        tx_bits.delete();
        pat = 16'hA5A5;
        for (int w = 0; w < 10; w++)
            for (int j = 0; j < 16; j++) tx_bits.push_back(pat[15-j]);
        model_window(0, 160);
        chk("model_t1_len", exp_q.size(), 11);
        chk("model_t1_w0", exp_q[0], 16'hA5A5);
        chk("model_t1_trl", exp_q[10], 16'hFFFF);
        drive_bits(0, 160, c0);
        idle_cycles(1);
        check_state("t1");
        chk("t1_latency", first_wr_cyc - c0, 18);
        chk("t1_frame_cnt_lit", frame_cnt, 1);

        // T2: two frames back-to-back
        gen_random(320);
        model_window(0, 320);
        drive_bits(0, 320, c0);
        idle_cycles(1);
        check_state("t2");
        chk("t2_frame_cnt_lit", frame_cnt, 3);

        // T3: 20 ones, partial frame
        tx_bits.delete();
        for (int i = 0; i < 20; i++) tx_bits.push_back(1'b1);
        model_window(0, 20);
        chk("model_t3_len", exp_q.size(), 3);
        chk("model_t3_w1", exp_q[1], 16'hF000);
        drive_bits(0, 20, c0);
        idle_cycles(1);
        check_state("t3");
        chk("t3_partial_lit", partial_err, 1);

        // T4: FIFO full around the third word's write
        gen_random(160);
        model_window(0, 160);
        exp_q.delete(2);
        m_overflow = 1'b1;
        fork
            drive_bits(0, 160, c0);
            begin
                repeat (42) @(posedge Clk);
                #1 fifo_full = 1'b1;
                repeat (16) @(posedge Clk);
                #1 fifo_full = 1'b0;
            end
        join
        idle_cycles(1);
        check_state("t4");

        // T5: Start_Readout clears flags one cycle after the synced edge
        chk("t5_pre_frame_cnt", frame_cnt, 4);
        chk("t5_pre_partial", partial_err, 1);
        chk("t5_pre_overflow", overflow, 1);
        @(posedge Clk); #1 Start_Readout = 1'b1;
        @(posedge Clk); #1;
        chk("t5_x1_overflow", overflow, 1);
        @(posedge Clk); #1;
        chk("t5_x2_frame_cnt", frame_cnt, 4);
        @(posedge Clk); #1;
        chk("t5_clr_frame_cnt", frame_cnt, 0);
        chk("t5_clr_partial", partial_err, 0);
        chk("t5_clr_overflow", overflow, 0);
        Start_Readout = 1'b0;
        m_frames = 0; m_partial = 1'b0; m_overflow = 1'b0;
        idle_cycles(4);

        // T6: reset at bit 70 of a frame
        gen_random(160);
        for (int w = 0; w < 4; w++) exp_q.push_back(word_at(16 * w, 16));
        drive_bits(0, 70, c0);
        @(posedge Clk); #1;
        reset_n = 1'b0; TransmitOn_n = 1'b1; Dout = 1'b0;
        #1;
        chk("t6_pre_writes", exp_q.size(), 0);
        chk("t6_rst_din", fifo_din, 0);
        chk("t6_rst_wr_en", fifo_wr_en, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_frame_cnt", frame_cnt, 0);
        repeat (3) @(posedge Clk);
        #1;
        chk("t6_hold_wr_en", fifo_wr_en, 0);
        reset_n = 1'b1;
        exp_q.delete();
        m_frames = 0; m_partial = 1'b0; m_overflow = 1'b0;
        idle_cycles(4);
        gen_random(160);
        model_window(0, 160);
        drive_bits(0, 160, c0);
        idle_cycles(1);
        check_state("t6_clean");
        chk("t6_frame_cnt_lit", frame_cnt, 1);

        // T7: window re-opened during TRAILER; its first bit is lost
        gen_random(68);
        model_window(0, 20);
        model_window(21, 47);
        drive_bits(0, 20, c0);
        idle_cycles(2);
        drive_bits(20, 48, c0);
        idle_cycles(1);
        check_state("t7");

        // T8: random transmissions
        for (int t = 0; t < 8; t++) begin
            n   = $urandom_range(1, 400);
            gap = $urandom_range(6, 12);
            gen_random(n);
            model_window(0, n);
            drive_bits(0, n, c0);
            idle_cycles(gap);
            check_state($sformatf("rnd%0d_n%0d", t, n));
        end

        // T9: Start_Readout synced edge lands on the frame completion cycle
        gen_random(160);
        model_window(0, 160);
        fork
            drive_bits(0, 160, c0);
            begin
                repeat (160) @(posedge Clk);
                #1 Start_Readout = 1'b1;
            end
        join
        m_frames = 0; m_partial = 1'b0; m_overflow = 1'b0;
        idle_cycles(1);
        check_state("t9");
        Start_Readout = 1'b0;
        idle_cycles(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/microroc_readout_deser.md
Name: microroc_readout_deser

Overview:
- Downstream of the DAQ acquisition/readout controller.
- During the ASIC RAM readout (after Start_Readout, before End_Readout falls), the ASIC chain shifts hit data serially on Dout, framed by TransmitOn_n.
- This block synchronizes those lines and packs the bits MSB-first into 16-bit words. It pushes the words into the USB-side event FIFO, followed by a trailer word at end of transmission.
- It also counts 160-bit ASIC frames and flags errors.

Parameters:
- WORD_W, 16, output word width.
- FRAME_BITS, 160, bits per ASIC frame (24 BCID + 128 hit + 8 chip ID); must be a multiple of WORD_W.
- TRAILER, 16'hFFFF, word written after each transmission.
- TRAILER_EN, 1, 1 = append trailer at end of transmission.

Ports:
- Clk  in  1  40 MHz system clock.
- reset_n  in  1  asynchronous active-low reset.
- Start_Readout  in  1  readout start from DAQ controller; rising edge clears counters and flags.
- Dout  in  1  ASIC serial data, asynchronous, one bit per Clk while TransmitOn_n low.
- TransmitOn_n  in  1  ASIC transmission active, active low, asynchronous.
- fifo_full  in  1  event FIFO full.
- fifo_din  out  16  word to FIFO.
- fifo_wr_en  out  1  one-cycle write strobe.
- frame_cnt  out  16  complete frames received since last clear, saturating at 16'hFFFF.
- partial_err  out  1  sticky: transmission ended mid-frame.
- overflow  out  1  sticky: a word was dropped because fifo_full.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: all outputs 0; sync registers TransmitOn_n=1, Dout=0; state IDLE.
- Sync: Dout and TransmitOn_n each pass through 2 flops; all logic uses the synced versions (dout_s, ton_s).
- A bit is valid in a cycle where ton_s=0.
- States: IDLE, SHIFT, FLUSH, TRAILER.
- IDLE:
  - ton_s=1 -> stay.
  - ton_s=0 -> shift this first bit in (bit_cnt=1, frame_bit=1) and go to SHIFT.
- SHIFT, each cycle with ton_s=0:
  - sreg <= {sreg[14:0], dout_s}; bit_cnt and frame_bit increment.
  - When bit_cnt reaches 16: word emitted next cycle (fifo_din=word, fifo_wr_en=1 for 1 cycle); bit_cnt wraps to 0.
  - First Dout bit lands in fifo_din[15].
  - When frame_bit reaches FRAME_BITS: frame_cnt += 1 (saturating); frame_bit wraps to 0.
- SHIFT, ton_s=1:
  - bit_cnt≠0 -> FLUSH.
  - bit_cnt=0 -> TRAILER if TRAILER_EN, else IDLE.
  - If frame_bit≠0: partial_err <= 1.
- FLUSH: emit partial word left-aligned, zero-padded in LSBs; clear counters; then TRAILER (or IDLE if TRAILER_EN=0).
- TRAILER: emit TRAILER for one cycle -> IDLE.
- Write with fifo_full=1: wr_en suppressed, word lost, overflow <= 1. The shift register keeps running; there is no backpressure to the ASIC.
- Emitted-word latency: 1 Clk after the 16th bit is sampled in the synced domain (3 Clk from pad).
- Start_Readout rising edge (edge-detect on registered copy):
  - Clears frame_cnt, partial_err, overflow.
  - Does not abort an ongoing transmission.
  - If the edge coincides with a frame completion, the clear wins.
- TransmitOn_n re-asserted while in FLUSH/TRAILER: the bits of those cycles are dropped, partial_err <= 1, and a new word starts from IDLE afterwards.
- Reset mid-transmission: immediate return to IDLE; partial data discarded; no write.
- frame_cnt: 16 bits, saturating, never wraps.

Decomposition:
- Shared package: state encodings, FRAME_BITS, default TRAILER, and the MICROROC frame field widths (BCID 24, hit 128, chip ID 8).
- One natural sub-module: sync2_edge (2-flop synchronizer with rise/fall detect outputs), reused for TransmitOn_n and Start_Readout.

Test Plan:
- Send 160 bits 0xA5A5 repeated ×10, TransmitOn_n low exactly 160 cycles -> 10 writes of 16'hA5A5 then 16'hFFFF, frame_cnt=1, partial_err=0.
- Send 2 frames back-to-back (320 bits, one contiguous TransmitOn_n window) -> 20 data words plus 1 trailer, frame_cnt=2.
- Send 20 bits all ones then deassert -> writes 16'hFFFF, 16'hF000, trailer; partial_err=1, frame_cnt=0.
- Hold fifo_full=1 during the 3rd word of a frame -> that word absent, overflow=1, remaining words still written in order.
- Pulse Start_Readout after the previous test -> frame_cnt=0, partial_err=0, overflow=0 one cycle after the synced edge.
- Assert reset_n=0 at bit 70 of a frame -> outputs 0 immediately, no further writes; next 160-bit frame yields a clean 10+1 words.
